// File: rtl/pwm_duty_decoder.sv
// Measures the period and high time of an asynchronous PWM line in clk cycles
// and reports the duty cycle in tenths, with stuck-line and short-period flags.
module pwm_duty_decoder #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [3:0]       duty_tenths,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEAS = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam int unsigned      RW     = CNT_W + 4;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  logic             sync_q, pwm_s, pwm_d;
  logic             rise;
  logic [CNT_W-1:0] cnt_p, cnt_h;
  logic [1:0]       state;
  logic [CNT_W-1:0] per_q, hi_q;
  logic [RW-1:0]    rem;
  logic [3:0]       q;
  logic [1:0]       bit_idx;
  logic             timeout;

  logic [RW-1:0]    div_shift;
  logic             rem_ge;
  logic [RW-1:0]    rem_nxt;
  logic [3:0]       q_nxt;

  assign rise = pwm_s & ~pwm_d;

  // Once stuck is flagged, further timeouts stay silent until a real result clears it.
  assign timeout = (cnt_p == TO_CNT) && !stuck && !rise;

  always_comb begin
    div_shift = RW'(per_q) << bit_idx;
    rem_ge    = (rem >= div_shift);
    rem_nxt   = rem;
    q_nxt     = q;
    if (rem_ge) begin
      rem_nxt = rem - div_shift;
      q_nxt   = q | (4'd1 << bit_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
      pwm_s  <= 1'b0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= pwm_in;
      pwm_s  <= sync_q;
      pwm_d  <= pwm_s;
    end
  end

  // Counters run in every state so the period after a latch is measured seamlessly.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p <= '0;
      cnt_h <= '0;
    end else if (rise) begin
      cnt_p <= CNT_W'(1);
      cnt_h <= CNT_W'(1);
    end else begin
      if (cnt_p != TO_CNT)
        cnt_p <= cnt_p + CNT_W'(1);
      if (pwm_s && (cnt_h != TO_CNT))
        cnt_h <= cnt_h + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      per_q       <= '0;
      hi_q        <= '0;
      rem         <= '0;
      q           <= '0;
      bit_idx     <= '0;
      period_out  <= '0;
      high_out    <= '0;
      duty_tenths <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEAS;
          end else if (timeout) begin
            valid       <= 1'b1;
            stuck       <= 1'b1;
            period_out  <= '0;
            high_out    <= '0;
            duty_tenths <= pwm_s ? 4'd10 : 4'd0;
          end
        end
        MEAS: begin
          if (rise) begin
            per_q   <= cnt_p;
            hi_q    <= cnt_h;
            rem     <= RW'(cnt_h) * RW'(10);
            q       <= '0;
            bit_idx <= 2'd3;
            state   <= DIV;
          end else if (timeout) begin
            valid       <= 1'b1;
            stuck       <= 1'b1;
            period_out  <= '0;
            high_out    <= '0;
            duty_tenths <= pwm_s ? 4'd10 : 4'd0;
            state       <= IDLE;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          if (rise)
            overrun <= 1'b1;
          if (bit_idx == 2'd0) begin
            period_out  <= per_q;
            high_out    <= hi_q;
            duty_tenths <= q_nxt;
            valid       <= 1'b1;
            stuck       <= 1'b0;
            state       <= MEAS;
          end else begin
            bit_idx <= bit_idx - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: event-level reference model compared
// every cycle, plus literal expectations on directed scenarios and random traffic.
module tb_pwm_duty_decoder;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwm_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic [3:0]       duty_tenths;
  logic             valid;
  logic             stuck;
  logic             overrun;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .period_out(period_out), .high_out(high_out), .duty_tenths(duty_tenths),
    .valid(valid), .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  // Reference model: pin samples delayed two clocks give the synchronized level;
  // results are expressed as events (latch, result 4 cycles later, timeout).
  int  cyc = 0;
  int  p_m2 = 0, p_m1 = 0, p_0 = 0, p1;
  int  lvl, rise_m;
  int  mode = 0, in_div = 0, div_last = 0, ref_c = 0, hi = 0, stuck_m = 0;
  int  pend_p, pend_h, pend_d;
  int  exp_valid = 0, exp_over = 0, exp_per = 0, exp_hi = 0, exp_duty = 0, exp_stuck = 0;
  bit  started = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("valid",   int'(valid),       exp_valid);
      chk("overrun", int'(overrun),     exp_over);
      chk("stuck",   int'(stuck),       exp_stuck);
      chk("period",  int'(period_out),  exp_per);
      chk("high",    int'(high_out),    exp_hi);
      chk("duty",    int'(duty_tenths), exp_duty);
    end
    cyc++;
    p1     = int'(pwm_in);
    lvl    = p_m1;
    rise_m = p_m1 & ~p_m2 & 1;
    if (reset) begin
      exp_valid = 0; exp_over = 0; exp_per = 0; exp_hi = 0; exp_duty = 0; exp_stuck = 0;
      mode = 0; in_div = 0; stuck_m = 0; hi = 0;
      ref_c = cyc + 1;
      p_0 = 0; p1 = 0;
      started = 1;
    end else begin
      exp_valid = 0;
      exp_over  = 0;
      if (in_div != 0) begin
        if (rise_m != 0) exp_over = 1;
        if (cyc == div_last) begin
          exp_valid = 1; exp_per = pend_p; exp_hi = pend_h; exp_duty = pend_d;
          exp_stuck = 0; stuck_m = 0; in_div = 0; mode = 1;
        end
      end else if (rise_m != 0) begin
        if (mode == 1) begin
          pend_p   = (cyc - ref_c > TIMEOUT) ? TIMEOUT : cyc - ref_c;
          pend_h   = (hi > TIMEOUT) ? TIMEOUT : hi;
          pend_d   = (pend_h * 10) / pend_p;
          div_last = cyc + 4;
          in_div   = 1;
        end
        mode = 1;
      end else if (stuck_m == 0 && (cyc - ref_c) >= TIMEOUT) begin
        exp_valid = 1; exp_stuck = 1; stuck_m = 1;
        exp_per = 0; exp_hi = 0; exp_duty = (lvl != 0) ? 10 : 0;
        mode = 0;
      end
      if (rise_m != 0) begin
        ref_c = cyc;
        hi    = 1;
      end else begin
        hi += lvl;
      end
    end
    p_m2 = p_m1;
    p_m1 = p_0;
    p_0  = p1;
  end

  // Captures the most recent reported result for the literal checks.
  int vcount = 0, ocount = 0, mcyc = 0, last_vcyc = 0, last_gap = 0;
  int last_per = 0, last_hi = 0, last_duty = 0, last_stuck = 0;

  always @(negedge clk) begin
    mcyc++;
    if (valid === 1'b1) begin
      vcount++;
      last_per   = int'(period_out);
      last_hi    = int'(high_out);
      last_duty  = int'(duty_tenths);
      last_stuck = int'(stuck);
      last_gap   = mcyc - last_vcyc;
      last_vcyc  = mcyc;
    end
    if (overrun === 1'b1) ocount++;
  end

  task automatic drive(input logic val, input int n);
    repeat (n) begin
      @(posedge clk); #2;
      pwm_in = val;
    end
  endtask

  task automatic pwm(input int per, input int hw, input int cnt);
    repeat (cnt) begin
      drive(1'b1, hw);
      drive(1'b0, per - hw);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  int vc, oc, per_r, hi_r;
  int steps [7] = '{5, 6, 7, 6, 5, 1, 9};

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",  int'(valid), 0);
    chk("rst_period", int'(period_out), 0);
    chk("rst_high",   int'(high_out), 0);
    chk("rst_duty",   int'(duty_tenths), 0);
    chk("rst_stuck",  int'(stuck), 0);
    chk("rst_vcount", vcount, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    pwm(10, 5, 6);
    chk("p10_period", last_per, 10);
    chk("p10_high",   last_hi, 5);
    chk("p10_duty",   last_duty, 5);
    chk("p10_gap",    last_gap, 10);

    foreach (steps[k]) begin
      pwm(10, steps[k], 3);
      chk("step_duty", last_duty, steps[k]);
    end

    pwm(23, 7, 4);
    chk("p23_period", last_per, 23);
    chk("p23_high",   last_hi, 7);
    chk("p23_duty",   last_duty, 3);

    drive(1'b1, 260);
    chk("to_hi_stuck",  last_stuck, 1);
    chk("to_hi_duty",   last_duty, 10);
    chk("to_hi_period", last_per, 0);
    chk("to_hi_high",   last_hi, 0);

    pwm(10, 5, 4);
    chk("resume_stuck", last_stuck, 0);
    chk("resume_duty",  last_duty, 5);

    drive(1'b0, 260);
    chk("to_lo_stuck", last_stuck, 1);
    chk("to_lo_duty",  last_duty, 0);

    pwm(10, 5, 4);
    oc = ocount;
    pwm(4, 2, 10);
    drive(1'b0, 8);
    chk("ovr_pulses", int'((ocount - oc) >= 4), 1);
    chk("ovr_period", last_per, 4);
    chk("ovr_duty",   last_duty, 5);

    // Reset lands on the second division cycle of the latch caused by this rise.
    pwm(10, 5, 3);
    drive(1'b1, 4);
    vc = vcount;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rdiv_valid",  int'(valid), 0);
    chk("rdiv_period", int'(period_out), 0);
    chk("rdiv_duty",   int'(duty_tenths), 0);
    drive(1'b1, 1);
    drive(1'b0, 3);
    chk("rdiv_noval", vcount - vc, 0);
    drive(1'b0, 2);
    pwm(10, 5, 3);
    chk("rdiv_restart_duty",   last_duty, 5);
    chk("rdiv_restart_period", last_per, 10);

    for (int k = 0; k < 40; k++) begin
      per_r = int'($urandom_range(6, 40));
      hi_r  = int'($urandom_range(1, per_r - 1));
      pwm(per_r, hi_r, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 7) == 0) pulse_reset();
    end
    drive(1'b0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
